// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage.
// Fetch drives the request and address; memory returns data with a one-cycle ack.
interface fetch_unit_if #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32
);
  logic                 imem_req;
  logic [WORD-1:0]      imem_addr;
  logic [INSTR_LEN-1:0] imem_rdata;
  logic                 imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/fetch_unit.sv
// LEGv8 fetch stage: owns the PC, fetches over imem req/ack,
// hands instructions to Decode and resolves the next PC on commit.
module fetch_unit #(
  parameter int              WORD      = 64,
  parameter int              INSTR_LEN = 32,
  parameter logic [WORD-1:0] RESET_PC  = '0,
  parameter int              TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_unit_if.master         imem,
  output logic [INSTR_LEN-1:0] instruction,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD-1:0]      pc,
  output logic [WORD-1:0]      pc_plus4,
  input  logic [2:0]           branch_op,
  input  logic [WORD-1:0]      branch_offset,
  input  logic [WORD-1:0]      reg_target,
  input  logic                 alu_zero,
  input  logic [3:0]           flags,
  input  logic                 halt,
  output logic                 halted,
  output logic                 misalign_err,
  output logic                 imem_timeout,
  output logic [31:0]          retired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    BOOT, REQ, REISSUE, HOLD, HALTED
  } state_e;

  state_e               state_q, state_d;
  logic [WORD-1:0]      pc_q, pc_d;
  logic [INSTR_LEN-1:0] instr_q, instr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [31:0]          retired_q, retired_d;
  logic                 mis_q, mis_d;
  logic                 to_q, to_d;

  logic            n_f, z_f, c_f, v_f;
  logic            cond_ok;
  logic [WORD-1:0] pc4, rel_tgt, next_pc;

  assign {n_f, z_f, c_f, v_f} = flags;
  assign pc4     = pc_q + WORD'(4);
  assign rel_tgt = pc_q + (branch_offset << 2);

  // B.cond: evaluate the condition field of the held instruction
  always_comb begin
    cond_ok = 1'b1;
    unique case (instr_q[3:0])
      4'h0:    cond_ok = z_f;
      4'h1:    cond_ok = !z_f;
      4'h2:    cond_ok = c_f;
      4'h3:    cond_ok = !c_f;
      4'h4:    cond_ok = n_f;
      4'h5:    cond_ok = !n_f;
      4'h6:    cond_ok = v_f;
      4'h7:    cond_ok = !v_f;
      4'h8:    cond_ok = c_f && !z_f;
      4'h9:    cond_ok = !(c_f && !z_f);
      4'hA:    cond_ok = (n_f == v_f);
      4'hB:    cond_ok = (n_f != v_f);
      4'hC:    cond_ok = !z_f && (n_f == v_f);
      4'hD:    cond_ok = !(!z_f && (n_f == v_f));
      default: cond_ok = 1'b1;
    endcase
  end

  // Next-PC selection from the branch operation
  always_comb begin
    next_pc = pc4;
    case (branch_op)
      3'd1, 3'd6: next_pc = rel_tgt;
      3'd2:       if (alu_zero) next_pc = rel_tgt;
      3'd3:       if (!alu_zero) next_pc = rel_tgt;
      3'd4:       if (cond_ok) next_pc = rel_tgt;
      3'd5:       next_pc = {reg_target[WORD-1:2], 2'b00};
      default:    next_pc = pc4;
    endcase
  end

  // Fetch FSM: request, timeout/reissue, hold for Decode, commit
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    retired_d = retired_q;
    mis_d     = mis_q;
    to_d      = to_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          to_d    = 1'b1;
          state_d = REISSUE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REISSUE: state_d = REQ;
      HOLD: begin
        if (instr_ready) begin
          pc_d      = {next_pc[WORD-1:2], 2'b00};
          retired_d = retired_q + 32'd1;
          if (branch_op == 3'd5 && reg_target[1:0] != 2'b00)
            mis_d = 1'b1;
          state_d = halt ? HALTED : REQ;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      cnt_q     <= '0;
      retired_q <= '0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      mis_q     <= mis_d;
      to_q      <= to_d;
    end
  end

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign instruction    = instr_q;
  assign instr_valid    = (state_q == HOLD);
  assign pc             = pc_q;
  assign pc_plus4       = instr_valid ? pc4 : '0;
  assign halted         = (state_q == HALTED);
  assign misalign_err   = mis_q;
  assign imem_timeout   = to_q;
  assign retired        = retired_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a commit-level reference model
// and a per-cycle compare process.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [63:0] pc, pc_plus4;
  logic [2:0]  branch_op = 3'd0;
  logic [63:0] branch_offset = '0;
  logic [63:0] reg_target = '0;
  logic        alu_zero = 1'b0;
  logic [3:0]  flags = 4'd0;
  logic        halt = 1'b0;
  logic        halted, misalign_err, imem_timeout;
  logic [31:0] retired;

  fetch_unit_if #(.WORD(64), .INSTR_LEN(32)) imem_bus ();

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem(imem_bus),
    .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .pc_plus4(pc_plus4),
    .branch_op(branch_op), .branch_offset(branch_offset),
    .reg_target(reg_target), .alu_zero(alu_zero), .flags(flags),
    .halt(halt), .halted(halted), .misalign_err(misalign_err),
    .imem_timeout(imem_timeout), .retired(retired)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;

  // reference model: state as it must be after the next rising edge
  logic [63:0] exp_pc = '0;
  logic [31:0] exp_instr = '0;
  logic [31:0] exp_retired = '0;
  bit exp_valid = 0, exp_halted = 0, exp_mis = 0, exp_to = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic bit cond_true(input logic [3:0] cc,
                                   input logic [3:0] f);
    bit n = f[3], z = f[2], c = f[1], v = f[0];
    bit r;
    case (cc >> 1)
      0: r = z;
      1: r = c;
      2: r = n;
      3: r = v;
      4: r = c && !z;
      5: r = (n == v);
      6: r = !z && (n == v);
      default: r = 1;
    endcase
    if (cc[0] && cc != 4'hF) r = !r;
    return r;
  endfunction

  function automatic logic [63:0] model_next(
    input int op, input logic [63:0] cur, input logic [63:0] off,
    input logic [63:0] tgt, input bit z, input logic [3:0] f,
    input logic [3:0] cc);
    logic [63:0] seq = cur + 64'd4;
    logic [63:0] rel = cur + off * 64'd4;
    case (op)
      1, 6: return rel;
      2: return z ? rel : seq;
      3: return z ? seq : rel;
      4: return cond_true(cc, f) ? rel : seq;
      5: return tgt & ~64'd3;
      default: return seq;
    endcase
  endfunction

  // per-cycle comparison against the model
  initial begin
    while (!done) begin
      @(posedge clk);
      #1;
      if (done) break;
      chk("pc", pc, exp_pc);
      chk("pc_plus4", pc_plus4, exp_valid ? exp_pc + 64'd4 : 64'd0);
      chk("instr_valid", instr_valid, exp_valid);
      if (exp_valid) chk("instruction", instruction, exp_instr);
      chk("retired", retired, exp_retired);
      chk("misalign_err", misalign_err, exp_mis);
      chk("imem_timeout", imem_timeout, exp_to);
      chk("halted", halted, exp_halted);
      if (exp_valid || exp_halted) chk("req_idle", imem_bus.imem_req, 0);
      if (imem_bus.imem_req) chk("imem_addr", imem_bus.imem_addr, exp_pc);
    end
  end

  task automatic model_reset();
    exp_pc = '0; exp_retired = '0;
    exp_valid = 0; exp_halted = 0; exp_mis = 0; exp_to = 0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_bus.imem_req && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", imem_bus.imem_req, 1);
  endtask

  task automatic ack_now(input logic [31:0] ins);
    imem_bus.imem_rdata = ins;
    imem_bus.imem_ack = 1'b1;
    exp_instr = ins;
    exp_valid = 1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
  endtask

  task automatic fetch(input logic [31:0] ins, input int dly);
    wait_req();
    repeat (dly) @(negedge clk);
    ack_now(ins);
  endtask

  task automatic commit(input int op, input logic [63:0] off,
                        input logic [63:0] tgt, input bit z,
                        input logic [3:0] f, input bit h);
    branch_op = op[2:0];
    branch_offset = off;
    reg_target = tgt;
    alu_zero = z;
    flags = f;
    halt = h;
    instr_ready = 1'b1;
    if (op == 5 && tgt[1:0] != 2'b00) exp_mis = 1;
    exp_pc = model_next(op, exp_pc, off, tgt, z, f, exp_instr[3:0]);
    exp_retired++;
    exp_valid = 0;
    if (h) exp_halted = 1;
    @(negedge clk);
    instr_ready = 1'b0;
    halt = 1'b0;
    branch_op = 3'd0;
  endtask

  initial begin
    int hi, lo;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 64'h0);
    chk("rst_instruction", instruction, 64'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_bus.imem_req, 0);
    chk("rst_retired", retired, 0);
    reset = 1'b0;

    // 1: basic fetch, stray ready while requesting is ignored
    wait_req();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    ack_now(32'h8B020020);
    chk("t1_instr", instruction, 64'h8B020020);
    commit(0, 0, 0, 0, 4'h0, 0);
    chk("t1_pc", pc, 64'h4);
    chk("t1_retired", retired, 1);

    // 2: B.cond EQ taken and not taken at 0x100
    fetch(32'hD503201F, 0);
    commit(1, 64'd63, 0, 0, 4'h0, 0);
    fetch(32'h54000040, 1);
    chk("t2_pc", pc, 64'h100);
    chk("t2_pc4", pc_plus4, 64'h104);
    commit(4, -64'sd2, 0, 0, 4'b0100, 0);
    chk("t2_eq_taken", pc, 64'hF8);
    fetch(32'h14000002, 0);
    commit(1, 64'd2, 0, 0, 4'h0, 0);
    fetch(32'h54000040, 0);
    commit(4, -64'sd2, 0, 0, 4'b0000, 0);
    chk("t2_eq_not", pc, 64'h104);

    // 3: CBNZ/CBZ, BR misaligned, BL, op 7, GE, HI, wrap
    fetch(32'h17FFFFC7, 0);
    commit(1, -64'sd57, 0, 0, 4'h0, 0);
    chk("t3_to_20", pc, 64'h20);
    fetch(32'hB5000000, 0);
    commit(3, 64'd5, 0, 0, 4'h0, 0);
    chk("t3_cbnz", pc, 64'h34);
    fetch(32'hB4000000, 0);
    commit(2, 64'd5, 0, 0, 4'h0, 0);
    chk("t3_cbz_not", pc, 64'h38);
    fetch(32'hD61F0000, 0);
    commit(5, 0, 64'h1003, 0, 4'h0, 0);
    chk("t3_br", pc, 64'h1000);
    chk("t3_misalign", misalign_err, 1);
    fetch(32'h94000004, 0);
    chk("t3_bl_link", pc_plus4, 64'h1004);
    commit(6, 64'd4, 0, 0, 4'h0, 0);
    chk("t3_bl", pc, 64'h1010);
    fetch(32'h00000000, 0);
    commit(7, 64'd9, 0, 0, 4'h0, 0);
    chk("t3_op7", pc, 64'h1014);
    fetch(32'h5400004A, 0);
    commit(4, 64'd3, 0, 0, 4'b1001, 0);
    chk("t3_ge", pc, 64'h1020);
    fetch(32'h54000048, 0);
    commit(4, 64'd3, 0, 0, 4'b0110, 0);
    chk("t3_hi_not", pc, 64'h1024);
    fetch(32'hD61F0000, 0);
    commit(5, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 4'h0, 0);
    fetch(32'hD503201F, 0);
    commit(0, 0, 0, 0, 4'h0, 0);
    chk("t3_wrap", pc, 64'h0);
    chk("t3_retired", retired, 15);

    // 4: request timeout and reissue at the same address
    wait_req();
    hi = 0;
    while (imem_bus.imem_req && hi < 40) begin
      hi++;
      if (hi == 16) exp_to = 1;
      @(negedge clk);
    end
    chk("t4_req_cycles", hi, 16);
    lo = 0;
    while (!imem_bus.imem_req && lo < 40) begin
      lo++;
      @(negedge clk);
    end
    chk("t4_gap_cycles", lo, 1);
    chk("t4_addr", imem_bus.imem_addr, 64'h0);
    chk("t4_timeout", imem_timeout, 1);
    ack_now(32'h8B010000);
    commit(0, 0, 0, 0, 4'h0, 0);

    // 5: reset while holding, ack right after release is ignored
    fetch(32'hAAAA5555, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("t5_pc", pc, 64'h0);
    chk("t5_valid", instr_valid, 0);
    chk("t5_sticky", {misalign_err, imem_timeout}, 0);
    reset = 1'b0;
    imem_bus.imem_rdata = 32'hDEADBEEF;
    imem_bus.imem_ack = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_valid", instr_valid, 0);
    fetch(32'h91000421, 2);
    commit(0, 0, 0, 0, 4'h0, 0);
    chk("t5_pc4", pc, 64'h4);

    // 6: halt on commit
    fetch(32'h1400000A, 0);
    commit(1, 64'd10, 0, 0, 4'h0, 1);
    imem_bus.imem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("t6_req_low", imem_bus.imem_req, 0);
      @(negedge clk);
      imem_bus.imem_ack = 1'b0;
    end
    chk("t6_halted", halted, 1);
    chk("t6_pc", pc, 64'h2C);
    chk("t6_retired", retired, 2);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
